my_alu_mul_seq: RTL and testbench
=================================

Name: my_alu_mul_seq

Overview:
- Multi-cycle 16-bit multiplier built on one my_alu instance, using shift-and-add.
- The block sequences the ALU control bits (zx, nx, zy, ny, f, no) and its x/y operands every cycle. It has a start/done handshake toward the CPU-side datapath.
- Result is the low 16 bits of a*b, which is correct for both unsigned and two's-complement operands.
- Provides the Hack-style multiply that the ALU itself lacks, with no second adder.

Parameters:
- EARLY_EXIT, 0, when 1 the sequence ends as soon as the remaining multiplier bits are all zero; when 0 latency is fixed.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  16  multiplicand, sampled on accepted start.
- b  input  16  multiplier, sampled on accepted start.
- busy  output  1  high while in ADD or DBL.
- done  output  1  one-cycle pulse when product is valid.
- product  output  16  registered result; holds until the next done.
- zr  output  1  product == 0 (combinational from the product register).
- ng  output  1  product[15].

Behaviour:
- Reset (async, rst_n=0): state=IDLE; internal registers acc, mcand, mplier, cnt cleared.
  - Output values in reset: product=0, done=0, busy=0, zr=1, ng=0.
  - A reset mid-operation aborts the multiply: no done pulse, product is unchanged from 0.
- Internal registers:
  - acc[15:0], accumulator.
  - mcand[15:0], shifted multiplicand.
  - mplier[15:0], remaining multiplier.
  - cnt[3:0], bit index.
- Fixed ALU configuration: the ALU is used only as x+y, i.e. zx=0 nx=0 zy=0 ny=0 f=1 no=0. In IDLE/DONE the ALU is driven with x=0, y=0 under the same control; its output is unused.
- States and transitions:
  - IDLE: if start=1, then mcand<=a, mplier<=b, acc<=0, cnt<=0, and go to ADD. Otherwise stay.
  - ADD: ALU x=acc, y=mcand. If mplier[0]=1, acc<=ALU out; else acc holds. Go to DBL.
  - DBL: ALU x=mcand, y=mcand. Update mcand<=ALU out (x2, wraps mod 2^16), mplier<=mplier>>1 (logical), cnt<=cnt+1.
    - If cnt==15, or (EARLY_EXIT=1 and mplier[15:1]==0): product<=acc and go to DONE.
    - Otherwise go to ADD.
  - DONE: done=1 for exactly this cycle; unconditionally go to IDLE.
- Handshake:
  - start is ignored in ADD, DBL and DONE; there is no queuing. A new start is accepted earliest in the cycle after DONE.
  - busy=1 exactly in ADD/DBL; busy is low during the done cycle.
- Latency, from the rising edge that samples start:
  - EARLY_EXIT=0: fixed 16 ADD/DBL pairs; done is high in the cycle after edge 33, i.e. 33 clocks.
  - EARLY_EXIT=1: 1 + 2k clocks, where k = position of the highest set bit of b, plus 1; minimum k=1. So b=0 and b=1 each take 3 clocks, and b=0x8000 takes 33.
- Arithmetic: all additions wrap mod 2^16; no overflow flag.
- Output stability:
  - product, zr and ng change only on the DBL→DONE edge (or reset), and stay stable across IDLE and the following operation.
  - start with a=b=0 still runs the full sequence and yields product=0, zr=1.

Test Plan:
- Reset, then start with a=3, b=5 (EARLY_EXIT=0) -> busy high for 32 cycles; done pulses once 33 clocks after start; product=0x000F, zr=0, ng=0.
- a=0xFFFD (-3), b=7 -> product=0xFFEB (-21), ng=1. Then a=0xFFFF, b=0xFFFF -> product=0x0001.
- a=0x0100, b=0x0100 -> product=0x0000, zr=1 (wrap-around), ng=0.
- Start with a=2, b=9; pulse start again with a=7, b=7 at cycles 5 and 33 (DONE cycle) -> both ignored; product=0x0012, exactly one done pulse.
- Drive rst_n=0 asynchronously mid-operation (cycle 10) -> immediately busy=0, done=0, product=0, zr=1. After release, a new start with a=4, b=4 -> product=0x0010.
- EARLY_EXIT=1 instance:
  - b=1, a=0x1234 -> done 3 clocks after start, product=0x1234.
  - b=0x8000, a=1 -> done at 33 clocks, product=0x8000, ng=1.

Source files
------------

// File: rtl/my_alu_mul_seq.sv
// ----------------------------------------------------------------------------
// my_alu_mul_seq
//   Multi-cycle 16x16 -> 16 shift-and-add multiplier. All additions go through
//   a single Hack-style ALU (my_alu) held at the x+y configuration. The
//   sequencer alternates ADD (acc += mcand when the current multiplier bit is
//   set) and DBL (mcand += mcand, multiplier shifted right). The low 16 bits
//   of the product are the same for unsigned and two's-complement operands.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request pulse; accepted only while idle
//   a, b     multiplicand / multiplier, captured on accepted start
//   busy     high in ADD and DBL
//   done     one-cycle pulse when product is updated
//   product  registered result; holds until the next done
//   zr, ng   product == 0, product[15]
//
// Parameter
//   EARLY_EXIT  1: stop once the remaining multiplier bits are all zero
//               0: fixed 16 ADD/DBL pairs
// ----------------------------------------------------------------------------

// Hack ALU core: only the data output is needed by the sequencer.
module my_alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out
);
    logic [15:0] x_z, x_n, y_z, y_n, res;

    always_comb begin
        x_z = zx ? 16'h0000 : x;
        x_n = nx ? ~x_z : x_z;
        y_z = zy ? 16'h0000 : y;
        y_n = ny ? ~y_z : y_z;
        res = f ? (x_n + y_n) : (x_n & y_n);
        out = no ? ~res : res;
    end
endmodule

module my_alu_mul_seq #(
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        zr,
    output logic        ng
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DBL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [15:0] acc, mcand, mplier;
    logic [3:0]  cnt;
    logic [15:0] alu_x, alu_y, alu_out;
    logic        last_pair;

    // ALU is permanently configured as x+y.
    my_alu u_alu (
        .x   (alu_x),
        .y   (alu_y),
        .zx  (1'b0),
        .nx  (1'b0),
        .zy  (1'b0),
        .ny  (1'b0),
        .f   (1'b1),
        .no  (1'b0),
        .out (alu_out)
    );

    // Last DBL of the sequence: bit 15 processed, or (early exit) no set bits
    // left above the one just handled.
    assign last_pair = (cnt == 4'd15) || (EARLY_EXIT && (mplier[15:1] == 15'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        alu_x    = 16'h0000;
        alu_y    = 16'h0000;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = ADD;
            ADD: begin
                alu_x    = acc;
                alu_y    = mcand;
                busy     = 1'b1;
                state_nx = DBL;
            end
            DBL: begin
                alu_x    = mcand;
                alu_y    = mcand;
                busy     = 1'b1;
                state_nx = last_pair ? DONE : ADD;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= 16'h0000;
            mcand   <= 16'h0000;
            mplier  <= 16'h0000;
            cnt     <= 4'd0;
            product <= 16'h0000;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mcand  <= a;
                    mplier <= b;
                    acc    <= 16'h0000;
                    cnt    <= 4'd0;
                end
                ADD: if (mplier[0]) acc <= alu_out;
                DBL: begin
                    mcand  <= alu_out;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 4'd1;
                    // acc already includes this bit's contribution from ADD.
                    if (last_pair) product <= acc;
                end
                default: ;
            endcase
        end
    end

    assign zr = (product == 16'h0000);
    assign ng = product[15];
endmodule

// File: tb/tb_my_alu_mul_seq.sv
module tb_my_alu_mul_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [15:0] a = 16'h0, b = 16'h0;
    logic        busy0, done0, zr0, ng0;
    logic        busy1, done1, zr1, ng1;
    logic [15:0] product0, product1;
    logic [15:0] prev0 = 16'h0, prev1 = 16'h0;
    int          cmp = 0, err = 0;

    always #5 clk = ~clk;

    my_alu_mul_seq #(.EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a), .b(b),
        .busy(busy0), .done(done0), .product(product0), .zr(zr0), .ng(ng0));

    my_alu_mul_seq #(.EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b),
        .busy(busy1), .done(done1), .product(product1), .zr(zr1), .ng(ng1));

    // Reference latency in clocks, counting the edge that samples start as 1.
    function automatic int exp_lat(input bit ee, input logic [15:0] bv);
        int k;
        if (!ee) return 33;
        k = 1;
        for (int i = 0; i < 16; i++) if (bv[i]) k = i + 1;
        return 1 + 2 * k;
    endfunction

    // One multiply on the selected instances; 40 edges observed so both
    // latency variants complete. poke re-pulses start0 with a=b=7 at cycles
    // 5 and 33, which must be ignored.
    task automatic do_op(input string nm, input logic [15:0] ta, input logic [15:0] tb,
                         input bit s0, input bit s1, input bit poke);
        logic [31:0] full;
        logic [15:0] exp;
        int el0, el1, lat0, lat1, nd0, nd1;
        bit bbad0, bbad1, pbad0, pbad1;
        full = 32'(ta) * 32'(tb);
        exp  = full[15:0];
        el0 = exp_lat(1'b0, tb);
        el1 = exp_lat(1'b1, tb);
        lat0 = -1; lat1 = -1; nd0 = 0; nd1 = 0;
        bbad0 = 0; bbad1 = 0; pbad0 = 0; pbad1 = 0;
        @(negedge clk);
        a = ta; b = tb; start0 = s0; start1 = s1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            start0 = 1'b0; start1 = 1'b0;
            if (done0) begin
                nd0++;
                if (lat0 < 0) lat0 = n;
                cmp++;
                if (product0 !== exp || zr0 !== (exp == 16'h0) || ng0 !== exp[15]) begin
                    err++;
                    $display("FAIL %s ee0 result: product=%h zr=%b ng=%b required product=%h zr=%b ng=%b",
                             nm, product0, zr0, ng0, exp, exp == 16'h0, exp[15]);
                end
                prev0 = exp;
            end
            if (done1) begin
                nd1++;
                if (lat1 < 0) lat1 = n;
                cmp++;
                if (product1 !== exp || zr1 !== (exp == 16'h0) || ng1 !== exp[15]) begin
                    err++;
                    $display("FAIL %s ee1 result: product=%h zr=%b ng=%b required product=%h zr=%b ng=%b",
                             nm, product1, zr1, ng1, exp, exp == 16'h0, exp[15]);
                end
                prev1 = exp;
            end
            if (busy0 !== (s0 && n < el0)) bbad0 = 1;
            if (busy1 !== (s1 && n < el1)) bbad1 = 1;
            if (product0 !== prev0) pbad0 = 1;
            if (product1 !== prev1) pbad1 = 1;
            if (poke && (n == 5 || n == 33)) begin
                start0 = 1'b1; a = 16'd7; b = 16'd7;
            end
        end
        cmp++;
        if (nd0 !== int'(s0) || (s0 && lat0 != el0)) begin
            err++;
            $display("FAIL %s ee0 done: pulses=%0d latency=%0d required pulses=%0d latency=%0d",
                     nm, nd0, lat0, int'(s0), s0 ? el0 : -1);
        end
        cmp++;
        if (nd1 !== int'(s1) || (s1 && lat1 != el1)) begin
            err++;
            $display("FAIL %s ee1 done: pulses=%0d latency=%0d required pulses=%0d latency=%0d",
                     nm, nd1, lat1, int'(s1), s1 ? el1 : -1);
        end
        cmp++;
        if (bbad0 || bbad1) begin
            err++;
            $display("FAIL %s busy: ee0 wrong=%b ee1 wrong=%b required both 0", nm, bbad0, bbad1);
        end
        cmp++;
        if (pbad0 || pbad1) begin
            err++;
            $display("FAIL %s product stability: ee0 changed=%b ee1 changed=%b required both 0",
                     nm, pbad0, pbad1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp++;
        if ({busy0, done0, product0, zr0, ng0} !== {1'b0, 1'b0, 16'h0, 1'b1, 1'b0} ||
            {busy1, done1, product1, zr1, ng1} !== {1'b0, 1'b0, 16'h0, 1'b1, 1'b0}) begin
            err++;
            $display("FAIL reset: ee0 busy=%b done=%b p=%h zr=%b ng=%b ee1 busy=%b done=%b p=%h zr=%b ng=%b required 0 0 0000 1 0",
                     busy0, done0, product0, zr0, ng0, busy1, done1, product1, zr1, ng1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        prev0 = 16'h0; prev1 = 16'h0;
    endtask

    task automatic test_directed();
        do_op("3x5",        16'd3,    16'd5,    1, 1, 0);
        do_op("m3x7",       16'hFFFD, 16'd7,    1, 1, 0);
        do_op("m1xm1",      16'hFFFF, 16'hFFFF, 1, 1, 0);
        do_op("wrap",       16'h0100, 16'h0100, 1, 1, 0);
        do_op("zero",       16'h0000, 16'h0000, 1, 1, 0);
        do_op("ee_b1",      16'h1234, 16'h0001, 1, 1, 0);
        do_op("ee_b8000",   16'h0001, 16'h8000, 1, 1, 0);
        do_op("b0",         16'hBEEF, 16'h0000, 1, 1, 0);
    endtask

    task automatic test_ignored_start();
        do_op("ignored_start", 16'd2, 16'd9, 1, 0, 1);
        cmp++;
        if (product0 !== 16'h0012) begin
            err++;
            $display("FAIL ignored_start final: product=%h required 0012", product0);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        a = 16'h1357; b = 16'h2468; start0 = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        cmp++;
        if ({busy0, done0, product0, zr0} !== {1'b0, 1'b0, 16'h0, 1'b1} ||
            {busy1, done1, product1, zr1} !== {1'b0, 1'b0, 16'h0, 1'b1}) begin
            err++;
            $display("FAIL mid_reset: ee0 busy=%b done=%b p=%h zr=%b ee1 busy=%b done=%b p=%h zr=%b required 0 0 0000 1",
                     busy0, done0, product0, zr0, busy1, done1, product1, zr1);
        end
        prev0 = 16'h0; prev1 = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op("after_reset", 16'd4, 16'd4, 1, 1, 0);
    endtask

    task automatic test_random();
        logic [15:0] ra, rb;
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom) >> $urandom_range(0, 15);
            do_op("random", ra, rb, 1, 1, 0);
        end
    endtask

    task automatic test_back_to_back();
        do_op("b2b_0", 16'h00FF, 16'h0003, 1, 1, 0);
        do_op("b2b_1", 16'h7FFF, 16'h0002, 1, 1, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored_start();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
